// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_pkg
// Description : Shared audio types: voice FSM states, default half-period
//               width and the note half-period table constants.
// Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam int c_HP_W_DEFAULT = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        REST = 2'd2
    } voice_state_t;

    // Half-period words for one octave of the note tables
    localparam logic [c_HP_W_DEFAULT-1:0] c_HP_C = 7'd95;
    localparam logic [c_HP_W_DEFAULT-1:0] c_HP_D = 7'd85;
    localparam logic [c_HP_W_DEFAULT-1:0] c_HP_E = 7'd75;
    localparam logic [c_HP_W_DEFAULT-1:0] c_HP_F = 7'd71;
    localparam logic [c_HP_W_DEFAULT-1:0] c_HP_G = 7'd63;
    localparam logic [c_HP_W_DEFAULT-1:0] c_HP_A = 7'd56;
    localparam logic [c_HP_W_DEFAULT-1:0] c_HP_B = 7'd50;

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational one-hot picker; search starts at i_ptr+1 and
//               wraps modulo N_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int N_REQ = 3,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_gnt
);

    logic w_found;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!w_found && i_req[i] && (((int'(i_ptr) + k) % N_REQ) == i)) begin
                    o_gnt[i] = 1'b1;
                    w_found  = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/voice_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : voice_arbiter
// Description : Shares one tone synthesizer among N_REQ note requesters in
//               fixed-length slots. Define VOICE_ARBITER_FIXED_PRIO_EN for
//               lowest-index-wins arbitration instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module voice_arbiter
    import audio_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int HP_W     = c_HP_W_DEFAULT,
    parameter int SLOT_LEN = 20,
    parameter int GATE_LEN = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   step_tick,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*HP_W-1:0]  req_hp,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       grant,
    output logic [HP_W-1:0]        hp,
    output logic                   active
);

    localparam int             c_PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [7:0]     c_SLOT_LAST = 8'(SLOT_LEN - 1);
    localparam logic [7:0]     c_GATE_LAST = 8'(GATE_LEN - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_RST = c_PTR_W'(N_REQ - 1);

    voice_state_t       r_state;
    logic [7:0]         r_cnt;
    logic               r_first;
    logic               r_active;
    logic [N_REQ-1:0]   r_grant;
    logic [HP_W-1:0]    r_hp;

    logic               w_boundary;
    logic               w_any;
    logic [N_REQ-1:0]   w_gnt;
    logic [HP_W-1:0]    w_hp;
    logic [c_PTR_W-1:0] w_ptr;

    // The first tick after reset opens a slot regardless of the counter
    assign w_boundary = step_tick && (r_first || (r_cnt == c_SLOT_LAST));
    assign w_any      = |req_valid;

`ifdef VOICE_ARBITER_FIXED_PRIO_EN
    assign w_ptr = c_PTR_RST;
`else
    logic [c_PTR_W-1:0] r_ptr;
    logic [c_PTR_W-1:0] w_win_idx;

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_win_idx = c_PTR_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= c_PTR_RST;
        end else if (|req_ready) begin
            r_ptr <= w_win_idx;
        end
    end

    assign w_ptr = r_ptr;
`endif

    rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (c_PTR_W)
    ) u_picker (
        .i_req (req_valid),
        .i_ptr (w_ptr),
        .o_gnt (w_gnt)
    );

    always_comb begin
        w_hp = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_hp = w_hp | req_hp[i*HP_W +: HP_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_first  <= 1'b1;
            r_active <= 1'b0;
            r_grant  <= '0;
            r_hp     <= '0;
        end else if (step_tick) begin
            r_first <= 1'b0;
            if (w_boundary) begin
                r_cnt <= '0;
                if (w_any) begin
                    r_state  <= GATE;
                    r_active <= 1'b1;
                    r_grant  <= w_gnt;
                    r_hp     <= w_hp;
                end else begin
                    r_state  <= IDLE;
                    r_active <= 1'b0;
                    r_grant  <= '0;
                end
            end else begin
                r_cnt <= r_cnt + 8'd1;
                if (r_state == GATE && r_cnt == c_GATE_LAST) begin
                    r_state  <= REST;
                    r_active <= 1'b0;
                end
            end
        end
    end

    assign req_ready = (w_boundary && !rst) ? w_gnt : '0;
    assign grant     = r_grant;
    assign hp        = r_hp;
    assign active    = r_active;

endmodule
`default_nettype wire

// File: tb/tb_voice_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_voice_arbiter
// Description : Self-checking bench for voice_arbiter against a slot-level
//               reference model; directed scenarios plus random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_voice_arbiter;

    localparam int N  = 3;
    localparam int W  = 7;
    localparam int SL = 20;
    localparam int GL = 10;

    logic           clk = 1'b0;
    logic           rst;
    logic           step_tick;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_hp;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic [W-1:0]   hp;
    logic           active;

    voice_arbiter #(
        .N_REQ    (N),
        .HP_W     (W),
        .SLOT_LEN (SL),
        .GATE_LEN (GL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .step_tick (step_tick),
        .req_valid (req_valid),
        .req_hp    (req_hp),
        .req_ready (req_ready),
        .grant     (grant),
        .hp        (hp),
        .active    (active)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Slot-level model: ticks since slot start, slot owner, last winner
    bit         m_first;
    int         m_pos;
    int         m_owner;
    int         m_last;
    logic [W-1:0] m_hp;

    logic [N-1:0] q_rdy[$];
    int           act_cnt;

    function automatic int pick(input logic [N-1:0] v, input int last);
        int start;
`ifdef VOICE_ARBITER_FIXED_PRIO_EN
        start = N - 1;
`else
        start = last;
`endif
        for (int k = 1; k <= N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int idx);
        logic [N-1:0] r;
        r = '0;
        if (idx >= 0) r[idx] = 1'b1;
        return r;
    endfunction

    task automatic reset_model();
        m_first = 1'b1;
        m_pos   = 0;
        m_owner = -1;
        m_last  = N - 1;
        m_hp    = '0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check at negedge, advance model to the next edge
    task automatic tick(input bit r, input bit s, input logic [N-1:0] v, input bit chk);
        bit           bnd;
        int           w;
        logic [N-1:0] exp_rdy;
        rst       = r;
        step_tick = s;
        req_valid = v;
        @(negedge clk);
        bnd     = s && (m_first || m_pos == SL - 1);
        w       = bnd ? pick(v, m_last) : -1;
        exp_rdy = r ? '0 : onehot(w);
        if (chk) begin
            check("req_ready", {29'd0, req_ready}, {29'd0, exp_rdy});
            check("grant", {29'd0, grant}, {29'd0, onehot(m_owner)});
            check("hp", {25'd0, hp}, {25'd0, m_hp});
            check("active", {31'd0, active}, {31'd0, (m_owner >= 0 && m_pos < GL)});
            if (req_ready !== '0) q_rdy.push_back(req_ready);
            if (active === 1'b1) act_cnt++;
        end
        if (r) begin
            reset_model();
        end else if (s) begin
            if (bnd) begin
                m_first = 1'b0;
                m_pos   = 0;
                m_owner = w;
                if (w >= 0) begin
                    m_hp   = req_hp[w*W +: W];
                    m_last = w;
                end
            end else begin
                m_pos++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input int per, input logic [N-1:0] v);
        for (int c = 0; c < n; c++) tick(1'b0, (c % per) == 0, v, 1'b1);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, '0, 1'b1);
    endtask

    initial begin
        logic [N-1:0] v;
        logic [N-1:0] nv;
        logic [N-1:0] exp_seq [4];

        rst = 1'b1; step_tick = 1'b0; req_valid = '0; req_hp = '0;
        reset_model();
        @(posedge clk);
        #1;
        tick(1'b1, 1'b0, '0, 1'b0);
        do_reset();

        // Single requester, tick every cycle
        req_hp[0*W +: W] = 7'd47;
        run(45, 1, 3'b001);

        // All requesting across four slots
        do_reset();
        req_hp = {7'd30, 7'd20, 7'd10};
        q_rdy.delete();
        run(4 * SL, 1, 3'b111);
`ifdef VOICE_ARBITER_FIXED_PRIO_EN
        exp_seq = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
        exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif
        check("rr_count", q_rdy.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("rr_seq", (i < q_rdy.size()) ? {29'd0, q_rdy[i]} : 32'hffff_ffff, {29'd0, exp_seq[i]});
        end

        // Empty boundary after a note with hp=62
        do_reset();
        req_hp[0*W +: W] = 7'd62;
        run(SL, 1, 3'b001);
        run(25, 1, 3'b000);
        check("idle_hp", {25'd0, hp}, 32'd62);
        check("idle_grant", {29'd0, grant}, 32'd0);
        check("idle_active", {31'd0, active}, 32'd0);

        // Late request from requester 1 waits for the boundary
        do_reset();
        req_hp = {7'd5, 7'd62, 7'd40};
        run(5, 1, 3'b001);
        run(20, 1, 3'b011);
        check("late_grant", {29'd0, grant}, 32'd2);

        // Reset pulse in the middle of GATE
        do_reset();
        req_hp[0*W +: W] = 7'd33;
        run(4, 1, 3'b001);
        tick(1'b1, 1'b1, 3'b001, 1'b1);
        check("mid_rst_active", {31'd0, active}, 32'd0);
        run(25, 1, 3'b011);

        // Slow prescaler: one tick every 4 clocks
        do_reset();
        act_cnt = 0;
        run(4 * SL, 4, 3'b100);
        check("slow_active_len", act_cnt, 4 * GL);
        run(100, 4, 3'b110);

        // Random traffic; hp only changes on idle requesters
        v = '0;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 9) == 0) begin
                nv = N'($urandom);
                for (int i = 0; i < N; i++) begin
                    if (!v[i]) req_hp[i*W +: W] = W'($urandom);
                end
                v = nv;
            end
            tick($urandom_range(0, 149) == 0, $urandom_range(0, 1) == 1, v, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
